// File: rtl/normalizer_pipe.sv
// normalizer_pipe: two-stage floating-point mantissa normaliser.
// Stage 1 registers the incoming beat together with its leading-zero count.
// Stage 2 applies an overflow, zero, right-shift (denormal), left-shift
// (normal) or left-shift (denormal) correction and registers the result.
// Both stages use a valid/ready handshake, so a stalled output holds steady
// and no beat is lost.
// Optional feature: define NORMALIZER_STICKY_EN to compute Sticky_o, which is
// the OR of the bits lost by the right shift. Without the macro, Sticky_o is
// tied to 0 and the OR tree is not built.
module normalizer_pipe #(
    parameter int PARM_EXP           = 8,
    parameter int PARM_MANT          = 23,
    parameter int PARM_LEADONE_WIDTH = 7,
    parameter int PARM_TAG           = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      In_valid_i,
    output logic                      In_ready_o,
    input  logic [3*PARM_MANT+4:0]    Mant_i,
    input  logic [PARM_EXP+1:0]       Exp_i,
    input  logic [PARM_TAG-1:0]       Tag_i,
    output logic                      Out_valid_o,
    input  logic                      Out_ready_i,
    output logic [3*PARM_MANT+4:0]    Mant_norm_o,
    output logic [PARM_EXP+1:0]       Exp_norm_o,
    output logic                      Sticky_o,
    output logic                      Denorm_o,
    output logic                      Ovf_o,
    output logic                      Zero_o,
    output logic [PARM_TAG-1:0]       Tag_o
);

    localparam int W  = 3*PARM_MANT+5;
    localparam int EW = PARM_EXP+2;
    localparam int LW = PARM_LEADONE_WIDTH;
    // Exponent arithmetic needs room for 1-E at the most negative E and for
    // the zero-extended shift count, so two guard bits are added.
    localparam int CW = ((EW > LW) ? EW : LW) + 2;

    localparam logic signed [CW-1:0] ONE_C  = CW'(1);
    localparam logic signed [CW-1:0] ZERO_C = '0;
    localparam logic signed [CW-1:0] W_C    = CW'(W);
    localparam logic signed [CW-1:0] OVF_C  = CW'((1 << PARM_EXP) - 1);

    logic          s1_valid;
    logic [W-1:0]  s1_mant;
    logic [EW-1:0] s1_exp;
    logic [PARM_TAG-1:0] s1_tag;
    logic [LW-1:0] s1_lz;

    logic          s2_valid;
    logic [W-1:0]  s2_mant;
    logic [EW-1:0] s2_exp;
    logic          s2_denorm;
    logic          s2_ovf;
    logic          s2_zero;
    logic [PARM_TAG-1:0] s2_tag;

    logic          s1_ready;
    logic          s2_ready;
    logic [LW-1:0] lz_c;

    logic signed [CW-1:0] e_ext;
    logic signed [CW-1:0] lz_ext;
    logic signed [CW-1:0] rs_ext;
    logic [LW-1:0] rs_amt;
    logic [W-1:0]  n_mant;
    logic [EW-1:0] n_exp;
    logic          n_denorm;
    logic          n_ovf;
    logic          n_zero;

    // A stage can take a new beat when it is empty or its content is leaving.
    always_comb begin
        s2_ready   = !s2_valid || Out_ready_i;
        s1_ready   = !s1_valid || s2_ready;
        In_ready_o = s1_ready;
    end

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lz_c = LW'(W);
        for (int i = 0; i < W; i++) begin
            if (Mant_i[i]) begin
                lz_c = LW'(W - 1 - i);
            end
        end
    end

    // Stage 1 valid bit; reset discards the beat in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= In_valid_i;
        end
    end

    // Stage 1 payload is captured only on an accepted beat.
    always_ff @(posedge clk_i) begin
        if (s1_ready && In_valid_i) begin
            s1_mant <= Mant_i;
            s1_exp  <= Exp_i;
            s1_tag  <= Tag_i;
            s1_lz   <= lz_c;
        end
    end

    // Normalisation decision. Priority: overflow, zero, right shift, left normal, left denormal.
    always_comb begin
        e_ext    = {{(CW-EW){s1_exp[EW-1]}}, s1_exp};
        lz_ext   = {{(CW-LW){1'b0}}, s1_lz};
        rs_ext   = ONE_C - e_ext;
        rs_amt   = (rs_ext >= W_C) ? LW'(W) : LW'(rs_ext);
        n_mant   = '0;
        n_exp    = '0;
        n_denorm = 1'b0;
        n_ovf    = 1'b0;
        n_zero   = 1'b0;
        if (e_ext >= OVF_C) begin
            n_ovf  = 1'b1;
            n_mant = s1_mant;
            n_exp  = s1_exp;
        end else if (s1_mant == '0) begin
            n_zero = 1'b1;
        end else if (e_ext <= ZERO_C) begin
            n_mant   = s1_mant >> rs_amt;
            n_denorm = 1'b1;
        end else if (e_ext > lz_ext) begin
            n_mant = s1_mant << s1_lz;
            n_exp  = EW'(e_ext - lz_ext);
        end else begin
            n_mant   = s1_mant << LW'(e_ext - ONE_C);
            n_denorm = 1'b1;
        end
    end

    // Stage 2 valid bit; reset discards the beat in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 payload changes only when a beat moves in, so a stall holds it.
    always_ff @(posedge clk_i) begin
        if (s2_ready && s1_valid) begin
            s2_mant   <= n_mant;
            s2_exp    <= n_exp;
            s2_denorm <= n_denorm;
            s2_ovf    <= n_ovf;
            s2_zero   <= n_zero;
            s2_tag    <= s1_tag;
        end
    end

`ifdef NORMALIZER_STICKY_EN
    localparam logic [W-1:0] ONES = '1;
    logic n_sticky;
    logic s2_sticky;

    // Sticky is the OR of the bits lost by the right shift. The shift is used only when E <= 0.
    always_comb begin
        n_sticky = 1'b0;
        if (e_ext <= ZERO_C) begin
            n_sticky = |(s1_mant & ~(ONES << rs_amt));
        end
    end

    // Sticky travels with the rest of the stage 2 payload.
    always_ff @(posedge clk_i) begin
        if (s2_ready && s1_valid) begin
            s2_sticky <= n_sticky;
        end
    end

    assign Sticky_o = s2_valid & s2_sticky;
`else
    assign Sticky_o = 1'b0;
`endif

    assign Out_valid_o = s2_valid;
    assign Mant_norm_o = s2_mant;
    assign Exp_norm_o  = s2_exp;
    assign Tag_o       = s2_tag;
    assign Denorm_o    = s2_valid & s2_denorm;
    assign Ovf_o       = s2_valid & s2_ovf;
    assign Zero_o      = s2_valid & s2_zero;

endmodule

// File: tb/tb_normalizer_pipe.sv
// tb_normalizer_pipe: self-checking bench for normalizer_pipe.
// The reference model works from the normalisation rules on plain integers and
// vectors. Accepted input beats and delivered output beats are collected into
// queues. Each test task compares the two queues itself.
module tb_normalizer_pipe;

    localparam int PARM_EXP  = 8;
    localparam int PARM_MANT = 23;
    localparam int PARM_TAG  = 4;
    localparam int W  = 3*PARM_MANT+5;
    localparam int EW = PARM_EXP+2;
    localparam int TW = PARM_TAG;
`ifdef NORMALIZER_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic [TW-1:0] tag;
    } in_t;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          sticky;
        logic          denorm;
        logic          ovf;
        logic          zero;
        logic [TW-1:0] tag;
    } out_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          In_valid_i;
    logic          In_ready_o;
    logic [W-1:0]  Mant_i;
    logic [EW-1:0] Exp_i;
    logic [TW-1:0] Tag_i;
    logic          Out_valid_o;
    logic          Out_ready_i;
    logic [W-1:0]  Mant_norm_o;
    logic [EW-1:0] Exp_norm_o;
    logic          Sticky_o;
    logic          Denorm_o;
    logic          Ovf_o;
    logic          Zero_o;
    logic [TW-1:0] Tag_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    in_t  acc_q[$];
    out_t out_q[$];
    int   acc_cyc[$];
    int   out_cyc[$];

    normalizer_pipe dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .In_valid_i  (In_valid_i),
        .In_ready_o  (In_ready_o),
        .Mant_i      (Mant_i),
        .Exp_i       (Exp_i),
        .Tag_i       (Tag_i),
        .Out_valid_o (Out_valid_o),
        .Out_ready_i (Out_ready_i),
        .Mant_norm_o (Mant_norm_o),
        .Exp_norm_o  (Exp_norm_o),
        .Sticky_o    (Sticky_o),
        .Denorm_o    (Denorm_o),
        .Ovf_o       (Ovf_o),
        .Zero_o      (Zero_o),
        .Tag_o       (Tag_o)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk_i = ~clk_i;

    // Watchdog that stops a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: a direct reading of the normalisation rules.
    function automatic out_t model(in_t b);
        out_t r;
        int e, lz, rs;
        logic [W-1:0] m;
        m = b.mant;
        e = int'($signed(b.exp));
        r = '0;
        r.tag = b.tag;
        lz = 0;
        while (lz < W && m[W-1-lz] == 1'b0) lz++;
        if (e >= (1 << PARM_EXP) - 1) begin
            r.ovf  = 1'b1;
            r.mant = m;
            r.exp  = EW'(e);
        end else if (m == '0) begin
            r.zero = 1'b1;
        end else if (e <= 0) begin
            rs = 1 - e;
            if (rs > W) rs = W;
            r.mant   = m >> rs;
            r.sticky = STICKY_EN && (m != (r.mant << rs));
            r.denorm = 1'b1;
        end else if (e > lz) begin
            r.mant = m << lz;
            r.exp  = EW'(e - lz);
        end else begin
            r.mant   = m << (e - 1);
            r.denorm = 1'b1;
        end
        return r;
    endfunction

    function automatic in_t mk_in(logic [W-1:0] m, int e, int t);
        in_t b;
        b.mant = m;
        b.exp  = EW'(e);
        b.tag  = TW'(t);
        return b;
    endfunction

    function automatic out_t mk_out(logic [W-1:0] m, int e, bit s, bit d, bit o, bit z, int t);
        out_t r;
        r.mant = m; r.exp = EW'(e); r.sticky = s; r.denorm = d;
        r.ovf = o; r.zero = z; r.tag = TW'(t);
        return r;
    endfunction

    function automatic in_t rand_beat(int t);
        in_t b;
        logic [95:0] r;
        int e;
        r = {$urandom, $urandom, $urandom};
        b.mant = W'(r) >> $urandom_range(0, W);
        case ($urandom_range(0, 3))
            0: e = int'($urandom_range(0, 20)) - 10;
            1: e = int'($urandom_range(0, 80));
            2: e = int'($urandom_range(240, 511));
            default: e = int'($urandom_range(0, 1023)) - 512;
        endcase
        b.exp = EW'(e);
        b.tag = TW'(t);
        return b;
    endfunction

    task automatic drive(in_t b);
        Mant_i = b.mant;
        Exp_i  = b.exp;
        Tag_i  = b.tag;
    endtask

    // One clock: record handshakes at the falling edge, then move 1 unit past the rising edge.
    task automatic step();
        @(negedge clk_i);
        if (!rst_i && In_valid_i && In_ready_o) begin
            acc_q.push_back({Mant_i, Exp_i, Tag_i});
            acc_cyc.push_back(cyc);
        end
        if (!rst_i && Out_valid_o && Out_ready_i) begin
            out_q.push_back({Mant_norm_o, Exp_norm_o, Sticky_o, Denorm_o, Ovf_o, Zero_o, Tag_o});
            out_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete(); out_q.delete(); acc_cyc.delete(); out_cyc.delete();
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        In_valid_i  = 1'b0;
        Out_ready_i = 1'b1;
        while (out_q.size() < acc_q.size() && budget > 0) begin
            step();
            budget--;
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; In_valid_i = 1'b0; Out_ready_i = 1'b0;
        Mant_i = '0; Exp_i = '0; Tag_i = '0;
        repeat (3) step();
        n_cmp++;
        if (Out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", Out_valid_o); end
        n_cmp++;
        if (In_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", In_ready_o); end
        n_cmp++;
        if ({Sticky_o, Denorm_o, Ovf_o, Zero_o} !== 4'b0000)
            begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {Sticky_o, Denorm_o, Ovf_o, Zero_o}); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_directed();
        in_t  vin[13];
        out_t vex[13];
        logic [W-1:0] one, ones;
        int n;
        one = W'(1); ones = '1;
        vin[0]  = mk_in(one << 70, 10, 0);             vex[0]  = mk_out(one << 73, 7, 0, 0, 0, 0, 0);
        vin[1]  = mk_in(one << 63, 5, 1);              vex[1]  = mk_out(one << 67, 0, 0, 1, 0, 0, 1);
        vin[2]  = mk_in('0, 20, 2);                    vex[2]  = mk_out('0, 0, 0, 0, 0, 1, 2);
        vin[3]  = mk_in(one << 70, 255, 3);            vex[3]  = mk_out(one << 70, 255, 0, 0, 1, 0, 3);
        vin[4]  = mk_in((one << 73) | W'(7), -2, 4);   vex[4]  = mk_out(one << 70, 0, STICKY_EN, 1, 0, 0, 4);
        vin[5]  = mk_in(ones, -512, 5);                vex[5]  = mk_out('0, 0, STICKY_EN, 1, 0, 0, 5);
        vin[6]  = mk_in(one << 70, 3, 6);              vex[6]  = mk_out(one << 72, 0, 0, 1, 0, 0, 6);
        vin[7]  = mk_in(one, 254, 7);                  vex[7]  = mk_out(one << 73, 181, 0, 0, 0, 0, 7);
        vin[8]  = mk_in(one << 73, 0, 8);              vex[8]  = mk_out(one << 72, 0, 0, 1, 0, 0, 8);
        vin[9]  = mk_in(one << 73, 1, 9);              vex[9]  = mk_out(one << 73, 1, 0, 0, 0, 0, 9);
        vin[10] = mk_in('0, 300, 10);                  vex[10] = mk_out('0, 300, 0, 0, 1, 0, 10);
        vin[11] = mk_in('0, -5, 11);                   vex[11] = mk_out('0, 0, 0, 0, 0, 1, 11);
        vin[12] = mk_in(W'(3), -1, 12);                vex[12] = mk_out('0, 0, STICKY_EN, 1, 0, 0, 12);
        clear_q();
        Out_ready_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            In_valid_i = 1'b1;
            drive(vin[i]);
            step();
        end
        drain();
        n_cmp++;
        if (out_q.size() != 13) begin n_fail++; $display("[TB] FAIL directed_count: got %0d expected 13", out_q.size()); end
        n = (out_q.size() < 13) ? out_q.size() : 13;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (out_q[i] !== vex[i]) begin n_fail++; $display("[TB] FAIL directed_%0d: got %h expected %h", i, out_q[i], vex[i]); end
            n_cmp++;
            if (out_cyc[i] - acc_cyc[i] != 2) begin n_fail++; $display("[TB] FAIL latency_%0d: got %0d expected 2", i, out_cyc[i] - acc_cyc[i]); end
        end
    endtask

    task automatic test_throughput();
        out_t ex;
        int n;
        clear_q();
        Out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            In_valid_i = 1'b1;
            drive(rand_beat(i));
            step();
        end
        n_cmp++;
        if (acc_q.size() != 10) begin n_fail++; $display("[TB] FAIL throughput_accept: got %0d expected 10", acc_q.size()); end
        drain();
        n_cmp++;
        if (out_q.size() != acc_q.size()) begin n_fail++; $display("[TB] FAIL throughput_count: got %0d expected %0d", out_q.size(), acc_q.size()); end
        n = (out_q.size() < acc_q.size()) ? out_q.size() : acc_q.size();
        for (int i = 0; i < n; i++) begin
            ex = model(acc_q[i]);
            n_cmp++;
            if (out_q[i] !== ex) begin n_fail++; $display("[TB] FAIL throughput_%0d: got %h expected %h", i, out_q[i], ex); end
            n_cmp++;
            if (out_cyc[i] != out_cyc[0] + i) begin n_fail++; $display("[TB] FAIL throughput_cycle_%0d: got %0d expected %0d", i, out_cyc[i], out_cyc[0] + i); end
        end
    endtask

    task automatic test_backpressure();
        in_t b[3];
        out_t ex, cur;
        int n;
        clear_q();
        Out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b[i] = rand_beat(i + 1);
            In_valid_i = 1'b1;
            drive(b[i]);
            step();
        end
        n_cmp++;
        if (acc_q.size() != 2) begin n_fail++; $display("[TB] FAIL stall_accepted: got %0d expected 2", acc_q.size()); end
        n_cmp++;
        if (In_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready: got %b expected 0", In_ready_o); end
        ex = model(b[0]);
        for (int k = 0; k < 3; k++) begin
            cur = {Mant_norm_o, Exp_norm_o, Sticky_o, Denorm_o, Ovf_o, Zero_o, Tag_o};
            n_cmp++;
            if (Out_valid_o !== 1'b1 || cur !== ex)
                begin n_fail++; $display("[TB] FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", k, Out_valid_o, cur, ex); end
            step();
        end
        Out_ready_i = 1'b1;
        step();
        In_valid_i = 1'b0;
        drain();
        n_cmp++;
        if (out_q.size() != 3) begin n_fail++; $display("[TB] FAIL release_count: got %0d expected 3", out_q.size()); end
        n = (out_q.size() < 3) ? out_q.size() : 3;
        for (int i = 0; i < n; i++) begin
            ex = model(b[i]);
            n_cmp++;
            if (out_q[i] !== ex) begin n_fail++; $display("[TB] FAIL release_beat_%0d: got %h expected %h", i, out_q[i], ex); end
            n_cmp++;
            if (out_cyc[i] != out_cyc[0] + i) begin n_fail++; $display("[TB] FAIL release_cycle_%0d: got %0d expected %0d", i, out_cyc[i], out_cyc[0] + i); end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        Out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            In_valid_i = 1'b1;
            drive(rand_beat(i + 1));
            step();
        end
        n_cmp++;
        if (Out_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_full: got %b expected 1", Out_valid_o); end
        rst_i = 1'b1;
        Out_ready_i = 1'b1;
        In_valid_i = 1'b1;
        drive(rand_beat(3));
        step();
        rst_i = 1'b0;
        In_valid_i = 1'b0;
        n_cmp++;
        if (Out_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", Out_valid_o); end
        n_cmp++;
        if (In_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", In_ready_o); end
        clear_q();
        repeat (6) step();
        n_cmp++;
        if (out_q.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_stale: got %0d beats expected 0", out_q.size()); end
    endtask

    task automatic test_random();
        in_t cur;
        out_t ex;
        bit pending;
        int sent, budget, sz, n;
        clear_q();
        pending = 1'b0; sent = 0; budget = 5000;
        cur = '0;
        while (sent < 300 && budget > 0) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                cur = rand_beat(sent);
                pending = 1'b1;
            end
            In_valid_i = pending;
            drive(cur);
            Out_ready_i = ($urandom_range(0, 3) != 0);
            sz = acc_q.size();
            step();
            if (acc_q.size() > sz) begin
                pending = 1'b0;
                sent++;
            end
            budget--;
        end
        drain();
        n_cmp++;
        if (sent != 300) begin n_fail++; $display("[TB] FAIL random_sent: got %0d expected 300", sent); end
        n_cmp++;
        if (out_q.size() != acc_q.size()) begin n_fail++; $display("[TB] FAIL random_count: got %0d expected %0d", out_q.size(), acc_q.size()); end
        n = (out_q.size() < acc_q.size()) ? out_q.size() : acc_q.size();
        for (int i = 0; i < n; i++) begin
            ex = model(acc_q[i]);
            n_cmp++;
            if (out_q[i] !== ex) begin n_fail++; $display("[TB] FAIL random_%0d: got %h expected %h", i, out_q[i], ex); end
        end
    endtask

    // Run each scenario in turn, then print the summary.
    initial begin
        test_reset();
        test_directed();
        test_throughput();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/normalizer_pipe.md
NORMALIZER_PIPE -- requirements
Module: normalizer_pipe

Interface
REQ-001 SHALL have parameter PARM_EXP, default 8, exponent field width.
REQ-002 SHALL have parameter PARM_MANT, default 23, fraction width; datapath width W = 3*PARM_MANT+5 (74 default).
REQ-003 SHALL have parameter PARM_LEADONE_WIDTH, default 7, shift-count width; requires 2^PARM_LEADONE_WIDTH > W.
REQ-004 SHALL have parameter PARM_TAG, default 4, sideband tag width.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 In_valid_i  input  1  input beat valid.
REQ-008 In_ready_o  output  1  block accepts beat when In_valid_i & In_ready_o.
REQ-009 Mant_i  input  W  unnormalised product/sum magnitude.
REQ-010 Exp_i  input  PARM_EXP+2  biased exponent, two's complement signed.
REQ-011 Tag_i  input  PARM_TAG  opaque sideband, passed through unchanged.
REQ-012 Out_valid_o  output  1  result valid.
REQ-013 Out_ready_i  input  1  downstream accepts result.
REQ-014 Mant_norm_o  output  W  normalised/denormalised magnitude.
REQ-015 Exp_norm_o  output  PARM_EXP+2  corrected exponent.
REQ-016 Sticky_o / Denorm_o / Ovf_o / Zero_o  output  1 each  status flags.
REQ-017 Tag_o  output  PARM_TAG  tag of the result beat.

Function
REQ-018 SHALL be a 2-stage pipeline: S1 registers inputs plus leading-zero count lz of Mant_i (lz = W when Mant_i = 0); S2 registers shifted results.
REQ-019 Latency SHALL be 2 cycles from accept to Out_valid_o with Out_ready_i high; throughput one beat/cycle.
REQ-020 Each stage SHALL advance when empty or its successor advances; In_ready_o = !S1_valid | S1_advance (combinational from Out_ready_i allowed).
REQ-021 While Out_valid_o & !Out_ready_i, all outputs SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-022 Priority in S2 (E = Exp_i, first match wins): Ovf, Zero, right-shift, left-normal, left-denormal.
REQ-023 Ovf: E >= 2^PARM_EXP-1 -> Ovf_o=1, Mant_norm_o = Mant_i, Exp_norm_o = E, no shift.
REQ-024 Zero: Mant_i = 0 -> Zero_o=1, Mant_norm_o=0, Exp_norm_o=0.
REQ-025 Right-shift: E <= 0 -> rs = 1-E saturated at W; Mant_norm_o = Mant_i >> rs; Sticky_o = OR of shifted-out bits; Exp_norm_o=0; Denorm_o=1.
REQ-026 Left-normal: E > lz -> Mant_norm_o = Mant_i << lz (MSB=1); Exp_norm_o = E-lz.
REQ-027 Left-denormal: 0 < E <= lz -> Mant_norm_o = Mant_i << (E-1); Exp_norm_o=0; Denorm_o=1.
REQ-028 Flags not set by the matching case SHALL be 0; left shifts SHALL never set Sticky_o.
REQ-029 Arithmetic on Exp SHALL be PARM_EXP+2 bits signed; rs computed without wrap for E = most-negative value.

Reset
REQ-030 rst_i high at a clock edge SHALL clear S1_valid, S2_valid; next cycle Out_valid_o=0, In_ready_o=1.
REQ-031 Data/flag registers need not reset but Out flags SHALL read 0 while Out_valid_o=0.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; beat offered during reset cycle is not accepted.

Configuration
REQ-033 Macro NORMALIZER_STICKY_EN: defined -> Sticky_o computed per REQ-025; undefined -> Sticky_o tied 0 and sticky OR tree omitted, all other behaviour identical.

Verification (defaults, W=74, bit 73 = MSB)
REQ-034 Mant=1<<70, E=10, Out_ready=1 -> after 2 cycles Mant=1<<73, Exp=7, all flags 0.
REQ-035 Mant=1<<63, E=5 -> Mant=1<<67, Exp=0, Denorm=1; Mant=0, E=20 -> Zero=1, Exp=0; E=255 -> Ovf=1, Mant unchanged.
REQ-036 Mant=(1<<73)|7, E=-2 (rs=3) -> Mant=1<<70, Exp=0, Denorm=1, Sticky=1 (0 if NORMALIZER_STICKY_EN undefined).
REQ-037 Out_ready=0, 3 beats offered tags 1,2,3 -> beats 1,2 accepted, In_ready=0, outputs stable; release -> tags 1,2,3 in order, one per cycle.
REQ-038 rst_i asserted for one cycle with both stages valid -> Out_valid_o=0 next cycle; no stale beat emerges afterwards.
